// File: rtl/wb_pkg.sv
// Shared types for the writeback queue stage: queue entry layout, width limits
// and the load size encoding used by the extension unit.
package wb_pkg;

    localparam int MAX_XLEN = 64;
    localparam int MAX_REGW = 8;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } load_size_e;

    // Payload fields are sized to the widest supported core; the stage uses the low XLEN/REGW bits.
    typedef struct packed {
        logic                regwrite;
        logic                memtoreg;
        logic                isbyte;
        logic                ishalf;
        logic                sign_ext;
        logic [MAX_REGW-1:0] rw;
        logic [MAX_XLEN-1:0] exout;
        logic [MAX_XLEN-1:0] data;
        logic                data_valid;
    } wb_entry_t;

    function automatic load_size_e load_size(input logic isbyte, input logic ishalf);
        if (isbyte) begin
            return SIZE_BYTE;
        end
        if (ishalf) begin
            return SIZE_HALF;
        end
        return SIZE_WORD;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load lane selection and sign/zero extension for the writeback stage.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  load_size_e      size,
    input  logic            sign_ext,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half loads ignore addr[0]; word loads pass the full aligned word through.
    always_comb begin
        byte_lane = data[{addr, 3'b000} +: 8];
        half_lane = data[{addr[1], 4'b0000} +: 16];
        ext       = data;
        case (size)
            SIZE_BYTE: ext = {{(XLEN-8){sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: ext = {{(XLEN-16){sign_ext & half_lane[15]}}, half_lane};
            default:   ext = data;
        endcase
    end

endmodule

// File: rtl/wb_queue_stage.sv
// In-order writeback queue: buffers retiring results, fills loads from in-order
// memory responses and drives a registered register-file write port.
module wb_queue_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_regwrite,
    input  logic                       in_memtoreg,
    input  logic                       in_isbyte,
    input  logic                       in_ishalf,
    input  logic                       in_signed,
    input  logic [REGW-1:0]            in_rw,
    input  logic [XLEN-1:0]            in_exout,
    input  logic                       mem_rsp_valid,
    input  logic [XLEN-1:0]            mem_rsp_data,
    output logic                       wb_we,
    output logic [REGW-1:0]            wb_rw,
    output logic [XLEN-1:0]            wb_wd,
    output logic [$clog2(DEPTH+1)-1:0] pend_count,
    input  logic [REGW-1:0]            lookup_rs,
    output logic                       lookup_hit,
    output logic                       resp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t       q [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   slot;
    logic [CW-1:0]   count;
    logic            fill_found;
    logic            enq;
    logic            deq;
    logic            fill;
    wb_entry_t       new_entry;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] retire_data;

    assign in_ready   = (count < CW'(DEPTH));
    assign pend_count = count;
    assign enq        = in_valid && in_ready;
    assign deq        = (count != '0) && q[head_ptr].data_valid;
    assign fill       = mem_rsp_valid && fill_found;

    // Walk occupied slots oldest-first: the first load still waiting is the fill target.
    always_comb begin
        fill_found = 1'b0;
        fill_ptr   = head_ptr;
        lookup_hit = 1'b0;
        slot       = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (!fill_found && q[slot].memtoreg && !q[slot].data_valid) begin
                    fill_found = 1'b1;
                    fill_ptr   = slot;
                end
                if (q[slot].regwrite && (q[slot].rw[REGW-1:0] == lookup_rs) &&
                    (lookup_rs != '0)) begin
                    lookup_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        new_entry            = '0;
        new_entry.regwrite   = in_regwrite;
        new_entry.memtoreg   = in_memtoreg;
        new_entry.isbyte     = in_isbyte;
        new_entry.ishalf     = in_ishalf;
        new_entry.sign_ext   = in_signed;
        new_entry.rw         = MAX_REGW'(in_rw);
        new_entry.exout      = MAX_XLEN'(in_exout);
        new_entry.data_valid = !in_memtoreg;
    end

    wb_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .size     (load_size(q[head_ptr].isbyte, q[head_ptr].ishalf)),
        .sign_ext (q[head_ptr].sign_ext),
        .addr     (q[head_ptr].exout[1:0]),
        .data     (q[head_ptr].data[XLEN-1:0]),
        .ext      (ext_data)
    );

    assign retire_data = q[head_ptr].memtoreg ? ext_data : q[head_ptr].exout[XLEN-1:0];

    // The fill target is always an occupied slot, so it never collides with the tail write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            if (fill) begin
                q[fill_ptr].data       <= MAX_XLEN'(mem_rsp_data);
                q[fill_ptr].data_valid <= 1'b1;
            end
            if (enq) begin
                q[tail_ptr] <= new_entry;
                tail_ptr    <= tail_ptr + 1'b1;
            end
            if (deq) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_we    <= 1'b0;
            wb_rw    <= '0;
            wb_wd    <= '0;
            resp_err <= 1'b0;
        end else begin
            wb_we <= deq && q[head_ptr].regwrite && (q[head_ptr].rw[REGW-1:0] != '0);
            if (deq) begin
                wb_rw <= q[head_ptr].rw[REGW-1:0];
                wb_wd <= retire_data;
            end
            if (mem_rsp_valid && !fill_found) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Self-checking bench for wb_queue_stage: rule-level queue model plus a
// scoreboard of expected writeback port values checked by a separate monitor.
module tb_wb_queue_stage;

    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_regwrite;
    logic            in_memtoreg;
    logic            in_isbyte;
    logic            in_ishalf;
    logic            in_signed;
    logic [REGW-1:0] in_rw;
    logic [XLEN-1:0] in_exout;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            wb_we;
    logic [REGW-1:0] wb_rw;
    logic [XLEN-1:0] wb_wd;
    logic [CW-1:0]   pend_count;
    logic [REGW-1:0] lookup_rs;
    logic            lookup_hit;
    logic            resp_err;

    wb_queue_stage #(
        .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_isbyte(in_isbyte), .in_ishalf(in_ishalf), .in_signed(in_signed),
        .in_rw(in_rw), .in_exout(in_exout),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_wd(wb_wd),
        .pend_count(pend_count),
        .lookup_rs(lookup_rs), .lookup_hit(lookup_hit),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          regwrite;
        bit          memtoreg;
        bit          isbyte;
        bit          ishalf;
        bit          sgn;
        logic [4:0]  rw;
        logic [31:0] exout;
        logic [31:0] data;
        bit          has_data;
    } model_entry_t;

    typedef struct {
        bit          we;
        logic [4:0]  rw;
        logic [31:0] wd;
    } wb_expect_t;

    model_entry_t mq[$];
    wb_expect_t   exp_q[$];
    bit           model_err;
    logic [4:0]   last_rw;
    logic [31:0]  last_wd;
    int           checks;
    int           failures;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] loadValue(input model_entry_t e);
        logic [31:0] v;
        int unsigned a;
        if (!e.memtoreg) begin
            return e.exout;
        end
        a = 32'(e.exout[1:0]);
        if (e.isbyte) begin
            v = (e.data >> (8 * a)) & 32'h0000_00FF;
            if (e.sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (e.ishalf) begin
            v = (e.data >> ((a >= 2) ? 16 : 0)) & 32'h0000_FFFF;
            if (e.sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = e.data;
        end
        return v;
    endfunction

    // One clock of stimulus: drive, check the state left by the last edge, then model the next edge.
    task automatic applyStimulus(input bit valid, input bit regwrite, input bit memtoreg,
                                 input bit isbyte, input bit ishalf, input bit sgn,
                                 input logic [4:0] rw, input logic [31:0] exout,
                                 input bit rsp, input logic [31:0] rsp_data,
                                 input logic [4:0] lrs);
        model_entry_t e;
        model_entry_t tmp;
        wb_expect_t   x;
        bit           hit;
        bit           found;
        bit           retire;
        bit           ready;
        @(posedge clk);
        #1;
        in_valid      = valid;
        in_regwrite   = regwrite;
        in_memtoreg   = memtoreg;
        in_isbyte     = isbyte;
        in_ishalf     = ishalf;
        in_signed     = sgn;
        in_rw         = rw;
        in_exout      = exout;
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp_data;
        lookup_rs     = lrs;
        @(negedge clk);
        hit = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].regwrite && mq[i].rw == lrs && mq[i].rw != 0) hit = 1'b1;
        end
        checkOutput("pend_count", 32'(pend_count), 32'(mq.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        checkOutput("lookup_hit", 32'(lookup_hit), 32'(hit));
        checkOutput("resp_err", 32'(resp_err), 32'(model_err));

        retire = (mq.size() > 0) && mq[0].has_data;
        ready  = (mq.size() < DEPTH);
        if (rsp) begin
            found = 1'b0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!found && mq[i].memtoreg && !mq[i].has_data) begin
                    tmp          = mq[i];
                    tmp.data     = rsp_data;
                    tmp.has_data = 1'b1;
                    mq[i]        = tmp;
                    found        = 1'b1;
                end
            end
            if (!found) model_err = 1'b1;
        end
        x.we = 1'b0;
        if (retire) begin
            e       = mq.pop_front();
            last_rw = e.rw;
            last_wd = loadValue(e);
            x.we    = e.regwrite && (e.rw != 0);
        end
        x.rw = last_rw;
        x.wd = last_wd;
        exp_q.push_back(x);
        if (valid && ready) begin
            e.regwrite = regwrite;
            e.memtoreg = memtoreg;
            e.isbyte   = isbyte;
            e.ishalf   = ishalf;
            e.sgn      = sgn;
            e.rw       = rw;
            e.exout    = exout;
            e.data     = 32'h0;
            e.has_data = !memtoreg;
            mq.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic [4:0] lrs);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, lrs);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        rst           = 1'b0;
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
        mq.delete();
        exp_q.delete();
        model_err = 1'b0;
        last_rw   = 5'd0;
        last_wd   = 32'h0;
        #1;
        checkOutput("reset_pend_count", 32'(pend_count), 32'd0);
        checkOutput("reset_wb_we", 32'(wb_we), 32'd0);
        checkOutput("reset_wb_rw", 32'(wb_rw), 32'd0);
        checkOutput("reset_wb_wd", wb_wd, 32'd0);
        checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Monitor: each edge after modelling starts has exactly one expected port image.
    initial begin
        wb_expect_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("wb_we", 32'(wb_we), 32'(x.we));
                checkOutput("wb_rw", 32'(wb_rw), 32'(x.rw));
                checkOutput("wb_wd", wb_wd, x.wd);
            end
        end
    end

    initial begin
        int  pending;
        bit  ld;
        int  drain;
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        in_valid      = 1'b0;
        in_regwrite   = 1'b0;
        in_memtoreg   = 1'b0;
        in_isbyte     = 1'b0;
        in_ishalf     = 1'b0;
        in_signed     = 1'b0;
        in_rw         = '0;
        in_exout      = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        lookup_rs     = '0;
        model_err     = 1'b0;
        last_rw       = 5'd0;
        last_wd       = 32'h0;
        doReset();

        $display("[TB] ALU result latency");
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd3, 32'h0000_1234, 0, 32'h0, 5'd3);
        idle(3, 5'd3);

        $display("[TB] load extension");
        applyStimulus(1, 1, 1, 1, 0, 1, 5'd7, 32'h0000_1001, 0, 32'h0, 5'd7);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h0000_8000, 5'd7);
        applyStimulus(1, 1, 1, 1, 0, 0, 5'd8, 32'h0000_1001, 0, 32'h0, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h0000_8000, 5'd0);
        applyStimulus(1, 1, 1, 0, 1, 1, 5'd9, 32'h0000_2002, 0, 32'h0, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h8001_0000, 5'd0);
        idle(3, 5'd0);

        $display("[TB] full queue of loads");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0, 5'(10 + i), 32'h100 + 32'(4 * i), 0, 32'h0, 5'd11);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 5'd20, 32'hCAFE_0000, 0, 32'h0, 5'd12);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'hA000_0000 + 32'(i), 5'd10);
        end
        idle(3, 5'd0);

        $display("[TB] in-order retire and lookup");
        applyStimulus(1, 1, 1, 0, 0, 0, 5'd5, 32'h0000_0040, 0, 32'h0, 5'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd6, 32'h0000_0666, 0, 32'h0, 5'd5);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd5);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 5'd6);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h5555_AAAA, 5'd5);
        idle(3, 5'd6);

        $display("[TB] stray responses");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h1111_1111, 5'd0);
        idle(2, 5'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, 5'd9, 32'h0, 1, 32'hDEAD_BEEF, 5'd9);
        idle(2, 5'd9);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h1234_5678, 5'd9);
        idle(3, 5'd0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0, 5'(1 + i), 32'h0, 0, 32'h0, 5'd1);
        end
        doReset();
        idle(4, 5'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1, 32'h7777_7777, 5'd0);
        idle(2, 5'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            pending = 0;
            foreach (mq[i]) if (mq[i].memtoreg && !mq[i].has_data) pending++;
            ld = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), ld,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          (pending > 0) && ($urandom_range(0, 1) == 1), $urandom(),
                          5'($urandom_range(0, 7)));
        end

        drain = 0;
        while (mq.size() > 0 && drain < 64) begin
            pending = 0;
            foreach (mq[i]) if (mq[i].memtoreg && !mq[i].has_data) pending++;
            applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, pending > 0, $urandom(), 5'd0);
            drain++;
        end
        checkOutput("model_drained", 32'(mq.size()), 32'd0);
        idle(3, 5'd0);
        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
